// File: rtl/fifo_rr_arbiter.sv
// Round-robin read arbiter that drains NUM_FIFOS upstream FIFOs into one downstream FIFO,
// loads FIFO thresholds during INIT. Optional build macro: ARB_PRIO0_EN (FIFO 0 strict priority).
module fifo_rr_arbiter #(
   parameter int DATA_BITS = 10,
   parameter int ADDR_BITS = 3,
   parameter int NUM_FIFOS = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           init,
   input  logic [ADDR_BITS-1:0]           umbral_af_in,
   input  logic [ADDR_BITS-1:0]           umbral_ae_in,
   input  logic [NUM_FIFOS-1:0]           fifo_empty_in,
   input  logic [NUM_FIFOS-1:0]           fifo_error_in,
   input  logic [NUM_FIFOS*DATA_BITS-1:0] fifo_data_in,
   input  logic                           out_almost_full_in,
   output logic [NUM_FIFOS-1:0]           fifo_read_out,
   output logic [DATA_BITS-1:0]           out_data,
   output logic                           out_write,
   output logic [ADDR_BITS-1:0]           umbral_af_out,
   output logic [ADDR_BITS-1:0]           umbral_ae_out,
   output logic [2:0]                     state_out,
   output logic                           idle_out,
   output logic                           error_out
);

   localparam int IDX_BITS = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_FIFOS - 1);

   typedef enum logic [2:0] {
      ST_RESET  = 3'b000,
      ST_INIT   = 3'b001,
      ST_IDLE   = 3'b010,
      ST_ACTIVE = 3'b011,
      ST_ERROR  = 3'b100
   } state_t;

   state_t                 state_reg;
   state_t                 state_next;
   logic [ADDR_BITS-1:0]   umbral_af_reg;
   logic [ADDR_BITS-1:0]   umbral_ae_reg;
   logic [IDX_BITS-1:0]    last_grant_reg;
   logic [IDX_BITS-1:0]    sel_reg;
   logic                   write_reg;

   logic [NUM_FIFOS-1:0]   pending_vec;
   logic [NUM_FIFOS-1:0]   rr_cand;
   logic                   any_pending;
   logic                   any_error;
   logic                   rr_valid;
   logic [IDX_BITS-1:0]    rr_idx;
   logic                   grant_valid;
   logic [IDX_BITS-1:0]    grant_idx;
   logic                   read_en;
   logic                   last_grant_upd;
   logic [DATA_BITS-1:0]   slice [NUM_FIFOS];

   assign pending_vec = ~fifo_empty_in;
   assign any_pending = |pending_vec;
   assign any_error   = |fifo_error_in;

`ifdef ARB_PRIO0_EN
   localparam logic [NUM_FIFOS-1:0] PRIO_MASK = NUM_FIFOS'(1);

   // FIFO 0 bypasses the rotation; the pointer only tracks the other FIFOs.
   assign rr_cand        = pending_vec & ~PRIO_MASK;
   assign grant_valid    = pending_vec[0] | rr_valid;
   assign grant_idx      = pending_vec[0] ? '0 : rr_idx;
   assign last_grant_upd = read_en && (grant_idx != '0);
`else
   assign rr_cand        = pending_vec;
   assign grant_valid    = rr_valid;
   assign grant_idx      = rr_idx;
   assign last_grant_upd = read_en;
`endif

   // Scan from farthest to nearest so the first candidate after last_grant wins.
   always_comb begin
      logic [IDX_BITS-1:0] idx;
      idx      = '0;
      rr_valid = 1'b0;
      rr_idx   = '0;
      for (int i = NUM_FIFOS; i >= 1; i--) begin
         idx = IDX_BITS'((int'(last_grant_reg) + i) % NUM_FIFOS);
         if (rr_cand[idx]) begin
            rr_valid = 1'b1;
            rr_idx   = idx;
         end
      end
   end

   assign read_en = (state_reg == ST_ACTIVE) && !out_almost_full_in && grant_valid;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
         assign slice[gi]         = fifo_data_in[gi*DATA_BITS +: DATA_BITS];
         assign fifo_read_out[gi] = read_en && (grant_idx == IDX_BITS'(gi));
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RESET:  state_next = ST_INIT;
         ST_INIT: begin
            if (any_error)       state_next = ST_ERROR;
            else if (!init)      state_next = ST_IDLE;
         end
         ST_IDLE: begin
            if (any_error)       state_next = ST_ERROR;
            else if (init)       state_next = ST_INIT;
            else if (any_pending) state_next = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (any_error)                       state_next = ST_ERROR;
            else if (!any_pending && !write_reg) state_next = ST_IDLE;
         end
         ST_ERROR:  state_next = ST_ERROR;
         default:   state_next = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_RESET;
         umbral_af_reg  <= '0;
         umbral_ae_reg  <= '0;
         last_grant_reg <= LAST_IDX;
         sel_reg        <= '0;
         write_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_INIT) begin
            umbral_af_reg <= umbral_af_in;
            umbral_ae_reg <= umbral_ae_in;
         end
         if (last_grant_upd) begin
            last_grant_reg <= grant_idx;
         end
         if (read_en) begin
            sel_reg <= grant_idx;
         end
         // A read issued on the edge that enters ERROR never reaches the output.
         write_reg <= read_en && (state_next != ST_ERROR);
      end
   end

   assign out_write     = write_reg && (state_reg != ST_ERROR) && (state_reg != ST_RESET);
   assign out_data      = out_write ? slice[sel_reg] : '0;
   assign umbral_af_out = umbral_af_reg;
   assign umbral_ae_out = umbral_ae_reg;
   assign state_out     = state_reg;
   assign idle_out      = (state_reg == ST_IDLE);
   assign error_out     = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: upstream FIFOs modelled as arrays with counters,
// expected word order derived from the arbitration rules at transaction level.
module tb_fifo_rr_arbiter;
   localparam int DW    = 10;
   localparam int AW    = 3;
   localparam int NF    = 4;
   localparam int DEPTH = 64;
   localparam logic [2:0] S_RESET  = 3'b000;
   localparam logic [2:0] S_INIT   = 3'b001;
   localparam logic [2:0] S_IDLE   = 3'b010;
   localparam logic [2:0] S_ACTIVE = 3'b011;
   localparam logic [2:0] S_ERROR  = 3'b100;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            init = 1'b0;
   logic [AW-1:0]   umbral_af_in = '0;
   logic [AW-1:0]   umbral_ae_in = '0;
   logic [NF-1:0]   fifo_empty_in;
   logic [NF-1:0]   fifo_error_in = '0;
   logic [NF*DW-1:0] fifo_data_in;
   logic            out_almost_full_in = 1'b0;
   logic [NF-1:0]   fifo_read_out;
   logic [DW-1:0]   out_data;
   logic            out_write;
   logic [AW-1:0]   umbral_af_out;
   logic [AW-1:0]   umbral_ae_out;
   logic [2:0]      state_out;
   logic            idle_out;
   logic            error_out;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fifo_rr_arbiter #(.DATA_BITS(DW), .ADDR_BITS(AW), .NUM_FIFOS(NF)) dut (
      .clk(clk), .reset(reset), .init(init),
      .umbral_af_in(umbral_af_in), .umbral_ae_in(umbral_ae_in),
      .fifo_empty_in(fifo_empty_in), .fifo_error_in(fifo_error_in),
      .fifo_data_in(fifo_data_in), .out_almost_full_in(out_almost_full_in),
      .fifo_read_out(fifo_read_out), .out_data(out_data), .out_write(out_write),
      .umbral_af_out(umbral_af_out), .umbral_ae_out(umbral_ae_out),
      .state_out(state_out), .idle_out(idle_out), .error_out(error_out)
   );

   // Upstream FIFO models: output word registered on read, empty flag updated at the edge.
   logic [DW-1:0] mem [NF][DEPTH];
   int            wr_cnt [NF] = '{default: 0};
   int            rd_cnt [NF] = '{default: 0};
   logic [DW-1:0] head_r [NF] = '{default: '0};
   logic [NF-1:0] empty_r = '1;

   always @(posedge clk) begin
      for (int k = 0; k < NF; k++) begin
         if (fifo_read_out[k] && (wr_cnt[k] != rd_cnt[k])) begin
            head_r[k] <= mem[k][rd_cnt[k] % DEPTH];
            rd_cnt[k] = rd_cnt[k] + 1;
         end
         empty_r[k] <= (wr_cnt[k] == rd_cnt[k]);
      end
   end

   assign fifo_empty_in = empty_r;
   always_comb begin
      fifo_data_in = '0;
      for (int k = 0; k < NF; k++) fifo_data_in[k*DW +: DW] = head_r[k];
   end

   logic [DW-1:0] exp_words[$];
   int            exp_grants[$];

   task automatic push(input int k, input logic [DW-1:0] w);
      mem[k][wr_cnt[k] % DEPTH] = w;
      wr_cnt[k] = wr_cnt[k] + 1;
   endtask

   task automatic flush();
      for (int k = 0; k < NF; k++) wr_cnt[k] = rd_cnt[k];
   endtask

   // Expected output order: cyclic service of non-empty FIFOs starting at FIFO 0.
   task automatic build_expected();
      int pos [NF];
      int last;
      int pick;
      int c;
      bit found;
      exp_words.delete();
      exp_grants.delete();
      for (int k = 0; k < NF; k++) pos[k] = rd_cnt[k];
      last = NF - 1;
      do begin
         found = 1'b0;
         pick  = 0;
`ifdef ARB_PRIO0_EN
         if (pos[0] < wr_cnt[0]) begin found = 1'b1; pick = 0; end
`endif
         for (int i = 1; i <= NF; i++) begin
            c = (last + i) % NF;
`ifdef ARB_PRIO0_EN
            if (!found && c != 0 && pos[c] < wr_cnt[c]) begin found = 1'b1; pick = c; end
`else
            if (!found && pos[c] < wr_cnt[c]) begin found = 1'b1; pick = c; end
`endif
         end
         if (found) begin
            exp_words.push_back(mem[pick][pos[pick] % DEPTH]);
            exp_grants.push_back(pick);
            pos[pick] = pos[pick] + 1;
`ifdef ARB_PRIO0_EN
            if (pick != 0) last = pick;
`else
            last = pick;
`endif
         end
      end while (found);
   endtask

   // Brings the DUT to IDLE with af=6, ae=1; returns on a falling edge.
   task automatic do_reset_init();
      @(negedge clk);
      reset = 1'b1; init = 1'b0; out_almost_full_in = 1'b0; fifo_error_in = '0;
      flush();
      repeat (2) @(negedge clk);
      reset = 1'b0; init = 1'b1; umbral_af_in = 3'd6; umbral_ae_in = 3'd1;
      repeat (2) @(negedge clk);
      init = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; init = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         tests_run++;
         if (state_out !== S_RESET || out_write !== 1'b0 || fifo_read_out !== '0 ||
             out_data !== '0 || idle_out !== 1'b0 || error_out !== 1'b0 ||
             umbral_af_out !== '0 || umbral_ae_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: got st=%b wr=%b rd=%b data=%h idle=%b err=%b af=%0d ae=%0d, required all zero",
                     state_out, out_write, fifo_read_out, out_data, idle_out, error_out, umbral_af_out, umbral_ae_out);
         end
      end
      reset = 1'b0; init = 1'b1; umbral_af_in = 3'd6; umbral_ae_in = 3'd1;
      @(negedge clk); #1;
      tests_run++;
      if (state_out !== S_INIT) begin
         tests_failed++; $display("FAIL init_entry: got state %b required %b", state_out, S_INIT);
      end
      @(negedge clk); #1;
      tests_run++;
      if (state_out !== S_INIT || umbral_af_out !== 3'd6 || umbral_ae_out !== 3'd1) begin
         tests_failed++;
         $display("FAIL init_load: got state %b af %0d ae %0d required 001 6 1", state_out, umbral_af_out, umbral_ae_out);
      end
      init = 1'b0;
      @(negedge clk); #1;
      tests_run++;
      if (state_out !== S_IDLE || idle_out !== 1'b1 || umbral_af_out !== 3'd6 || umbral_ae_out !== 3'd1) begin
         tests_failed++;
         $display("FAIL idle_entry: got state %b idle %b af %0d ae %0d required 010 1 6 1",
                  state_out, idle_out, umbral_af_out, umbral_ae_out);
      end
      $display("[TB] reset/init sequence done, state %b", state_out);
   endtask

   task automatic test_threshold_hold();
      umbral_af_in = 3'd2; umbral_ae_in = 3'd5;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if (umbral_af_out !== 3'd6 || umbral_ae_out !== 3'd1) begin
         tests_failed++;
         $display("FAIL threshold_hold: got af %0d ae %0d required 6 1", umbral_af_out, umbral_ae_out);
      end
   endtask

   task automatic test_rr_order();
      logic [NF-1:0] exp_rd [8];
      logic          exp_wr [8];
      logic [DW-1:0] exp_dt [8];
      logic [2:0]    exp_st [8];
`ifdef ARB_PRIO0_EN
      exp_rd = '{4'h0, 4'h1, 4'h1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
      exp_dt = '{10'h0, 10'h0, 10'h011, 10'h012, 10'h201, 10'h202, 10'h0, 10'h0};
`else
      exp_rd = '{4'h0, 4'h1, 4'h4, 4'h1, 4'h4, 4'h0, 4'h0, 4'h0};
      exp_dt = '{10'h0, 10'h0, 10'h011, 10'h201, 10'h012, 10'h202, 10'h0, 10'h0};
`endif
      exp_wr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_st = '{S_IDLE, S_ACTIVE, S_ACTIVE, S_ACTIVE, S_ACTIVE, S_ACTIVE, S_ACTIVE, S_IDLE};
      do_reset_init();
      push(0, 10'h011); push(0, 10'h012); push(2, 10'h201); push(2, 10'h202);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk); #1;
         tests_run++;
         if (fifo_read_out !== exp_rd[c] || out_write !== exp_wr[c] || out_data !== exp_dt[c] ||
             state_out !== exp_st[c]) begin
            tests_failed++;
            $display("FAIL rr_order cycle %0d: got rd=%b wr=%b data=%h st=%b required rd=%b wr=%b data=%h st=%b",
                     c, fifo_read_out, out_write, out_data, state_out, exp_rd[c], exp_wr[c], exp_dt[c], exp_st[c]);
         end
         if (out_write) $display("[TB] rr_order write %h", out_data);
      end
   endtask

   task automatic test_backpressure();
      logic [NF-1:0] prev_rd;
      bit            done;
      do_reset_init();
      for (int k = 0; k < NF; k++)
         for (int j = 0; j < 3; j++) push(k, DW'(k * 'h100 + j + 'h10));
      build_expected();
      prev_rd = '0;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         out_almost_full_in = (c >= 4 && c < 7);
         #1;
         if (out_almost_full_in) begin
            tests_run++;
            if (fifo_read_out !== '0) begin
               tests_failed++; $display("FAIL bp_read_blocked cycle %0d: got rd=%b required 0", c, fifo_read_out);
            end
         end
         if (c == 4) begin
            tests_run++;
            if (out_write !== 1'b1) begin
               tests_failed++; $display("FAIL bp_pending_write: got out_write %b required 1", out_write);
            end
         end
         tests_run++;
         if (out_write !== (prev_rd != '0)) begin
            tests_failed++;
            $display("FAIL bp_latency cycle %0d: got out_write %b required %b", c, out_write, prev_rd != '0);
         end
         if (out_write) begin
            tests_run++;
            if (exp_words.size() == 0) begin
               tests_failed++; $display("FAIL bp_extra_word: got %h required none", out_data);
            end else if (out_data !== exp_words[0]) begin
               tests_failed++; $display("FAIL bp_word: got %h required %h", out_data, exp_words[0]);
               void'(exp_words.pop_front());
            end else begin
               void'(exp_words.pop_front());
            end
            $display("[TB] backpressure write %h", out_data);
         end
         prev_rd = fifo_read_out;
         if (state_out == S_IDLE && c > 2) done = 1'b1;
      end
      out_almost_full_in = 1'b0;
      tests_run++;
      if (!done || exp_words.size() != 0) begin
         tests_failed++;
         $display("FAIL bp_drain_complete: got idle=%b remaining=%0d required idle=1 remaining=0", done, exp_words.size());
      end
   endtask

   task automatic test_random();
      logic [NF-1:0] prev_rd;
      bit            done;
      int            n;
      for (int it = 0; it < 12; it++) begin
         do_reset_init();
         for (int k = 0; k < NF; k++) begin
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) push(k, DW'($urandom));
         end
         build_expected();
         prev_rd = '0;
         done = 1'b0;
         for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            out_almost_full_in = ($urandom_range(0, 3) == 0);
            #1;
            tests_run++;
            if (!$onehot0(fifo_read_out) || (fifo_read_out & fifo_empty_in) != '0 ||
                (out_almost_full_in && fifo_read_out != '0)) begin
               tests_failed++;
               $display("FAIL rand_read_legal it %0d cycle %0d: got rd=%b empty=%b af=%b required legal one-hot read",
                        it, c, fifo_read_out, fifo_empty_in, out_almost_full_in);
            end
            tests_run++;
            if (out_write !== (prev_rd != '0)) begin
               tests_failed++;
               $display("FAIL rand_latency it %0d cycle %0d: got out_write %b required %b", it, c, out_write, prev_rd != '0);
            end
            if (out_write) begin
               tests_run++;
               if (exp_words.size() == 0) begin
                  tests_failed++; $display("FAIL rand_extra_word it %0d: got %h required none", it, out_data);
               end else if (out_data !== exp_words[0]) begin
                  tests_failed++; $display("FAIL rand_word it %0d: got %h required %h", it, out_data, exp_words[0]);
                  void'(exp_words.pop_front());
               end else begin
                  void'(exp_words.pop_front());
               end
               $display("[TB] random it %0d write %h", it, out_data);
            end
            prev_rd = fifo_read_out;
            if (state_out == S_IDLE && c > 2) done = 1'b1;
         end
         out_almost_full_in = 1'b0;
         tests_run++;
         if (!done || exp_words.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_drain it %0d: got idle=%b remaining=%0d required idle=1 remaining=0", it, done, exp_words.size());
         end
      end
   endtask

   task automatic test_prio_order();
      int  got[$];
      int  exp_g [5];
      bit  done;
`ifdef ARB_PRIO0_EN
      exp_g = '{0, 0, 0, 3, 3};
`else
      exp_g = '{0, 3, 0, 3, 0};
`endif
      do_reset_init();
      push(0, 10'h0A1); push(0, 10'h0A2); push(0, 10'h0A3);
      push(3, 10'h3B1); push(3, 10'h3B2);
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk); #1;
         for (int k = 0; k < NF; k++) if (fifo_read_out[k]) got.push_back(k);
         if (out_write) $display("[TB] grant_order write %h", out_data);
         if (state_out == S_IDLE && c > 2) done = 1'b1;
      end
      tests_run++;
      if (got.size() != 5) begin
         tests_failed++; $display("FAIL grant_count: got %0d grants required 5", got.size());
      end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         tests_run++;
         if (got[i] != exp_g[i]) begin
            tests_failed++; $display("FAIL grant_order[%0d]: got %0d required %0d", i, got[i], exp_g[i]);
         end
      end
   endtask

   task automatic test_error();
      bit seen;
      do_reset_init();
      for (int j = 0; j < 4; j++) begin push(0, DW'('h050 + j)); push(1, DW'('h150 + j)); end
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk); #1;
         if (fifo_read_out != '0) seen = 1'b1;
      end
      tests_run++;
      if (!seen) begin
         tests_failed++; $display("FAIL error_setup: got no read within 10 cycles required a read");
      end
      fifo_error_in = 4'b0010;
      @(negedge clk);
      fifo_error_in = '0;
      for (int c = 0; c < 4; c++) begin
         #1;
         tests_run++;
         if (state_out !== S_ERROR || error_out !== 1'b1 || idle_out !== 1'b0 ||
             fifo_read_out !== '0 || out_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL error_sticky cycle %0d: got st=%b err=%b rd=%b wr=%b required 100 1 0 0",
                     c, state_out, error_out, fifo_read_out, out_write);
         end
         @(negedge clk);
      end
      $display("[TB] error state held, state %b", state_out);
   endtask

   task automatic test_reset_mid();
      bit seen;
      do_reset_init();
      for (int j = 0; j < 4; j++) push(2, DW'('h260 + j));
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk); #1;
         if (fifo_read_out != '0) seen = 1'b1;
      end
      tests_run++;
      if (!seen) begin
         tests_failed++; $display("FAIL reset_mid_setup: got no read within 10 cycles required a read");
      end
      reset = 1'b1;
      @(negedge clk); #1;
      tests_run++;
      if (out_write !== 1'b0 || state_out !== S_RESET || umbral_af_out !== '0 ||
          umbral_ae_out !== '0 || fifo_read_out !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid: got wr=%b st=%b af=%0d ae=%0d rd=%b required 0 000 0 0 0",
                  out_write, state_out, umbral_af_out, umbral_ae_out, fifo_read_out);
      end
      $display("[TB] reset during read, state %b", state_out);
   endtask

   initial begin
      test_reset();
      test_threshold_hold();
      test_rr_order();
      test_backpressure();
      test_prio_order();
      test_random();
      test_error();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
